// File: rtl/param_reg_bank.sv
// Parametrised control/status register bank: NUM_REGS RW data registers with RO mirrors,
// a sticky W1C change-status register, and a registered valid/ready response. Optional macro: REGBANK_ERR_EN.
module param_reg_bank #(
  parameter int unsigned       NUM_REGS = 2,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [DATA_W-1:0] RST_EVEN = '0,
  parameter logic [DATA_W-1:0] RST_ODD  = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned       STRB_W      = DATA_W / 8;
  localparam int unsigned       IDX_W       = ADDR_W - 3;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  rsp_state_e          r_state;
  rsp_state_e          w_state_next;
  logic [DATA_W-1:0]   r_data [NUM_REGS];
  logic [NUM_REGS-1:0] r_status;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_aligned;
  logic [IDX_W-1:0]    w_idx;
  logic                w_status_hit;
  logic [NUM_REGS-1:0] w_data_sel;
  logic [NUM_REGS-1:0] w_mirror_sel;
  logic [DATA_W-1:0]   w_wmask;
  logic [DATA_W-1:0]   w_merged [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_en;
  logic [NUM_REGS-1:0] w_status_set;
  logic [NUM_REGS-1:0] w_status_clr;
  logic [DATA_W-1:0]   w_rd_value;
  logic                w_err;

  assign req_ready = (r_state == RSP_EMPTY) || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // Address decode: the STATUS constant has zero low bits, so an exact match implies alignment.
  assign w_aligned    = (req_addr[1:0] == 2'b00);
  assign w_idx        = req_addr[ADDR_W-1:3];
  assign w_status_hit = (req_addr == STATUS_ADDR);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
  always_comb begin
    w_data_sel   = '0;
    w_mirror_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_data_sel[i]   = w_aligned && !req_addr[2] && (w_idx == IDX_W'(i));
      w_mirror_sel[i] = w_aligned &&  req_addr[2] && (w_idx == IDX_W'(i));
    end
  end

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      w_wmask[8*b +: 8] = {8{req_wstrb[b]}};
    end
  end

  // Byte-lane merge and change detection; a zero strobe merges back to the old value.
  always_comb begin
    w_wr_en      = '0;
    w_status_set = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_merged[i]     = (r_data[i] & ~w_wmask) | (req_wdata & w_wmask);
      w_wr_en[i]      = w_accept && req_write && w_data_sel[i];
      w_status_set[i] = w_wr_en[i] && (w_merged[i] != r_data[i]);
    end
  end

  assign w_status_clr = (w_accept && req_write && w_status_hit)
                      ? (req_wdata[NUM_REGS-1:0] & w_wmask[NUM_REGS-1:0])
                      : '0;

  always_comb begin
    w_rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_data_sel[i] || w_mirror_sel[i]) begin
        w_rd_value = r_data[i];
      end
    end
    if (w_status_hit) begin
      w_rd_value = DATA_W'(r_status);
    end
  end

`ifdef REGBANK_ERR_EN
  assign w_err = !((|w_data_sel) || (|w_mirror_sel) || w_status_hit)
              || (req_write && (|w_mirror_sel));
`else
  assign w_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_data[i] <= (i % 2 == 0) ? RST_EVEN : RST_ODD;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en[i]) begin
          r_data[i] <= w_merged[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | w_status_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RSP_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RSP_EMPTY: if (w_accept) w_state_next = RSP_FULL;
      RSP_FULL:  if (!w_accept && rsp_ready) w_state_next = RSP_EMPTY;
    endcase
  end

  // Payload only moves on acceptance, so it holds stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_rdata <= req_write ? '0 : w_rd_value;
      r_rsp_err   <= w_err;
    end
  end

  assign rsp_valid = (r_state == RSP_FULL);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/param_reg_bank.md
# param_reg_bank

Parametrised register bank for peripheral control and status: NUM_REGS read-write data registers, each with a read-only mirror, plus a sticky write-1-to-clear change-status register. It sits behind the bus-to-register bridge on a valid/ready request/response interface. Compared with the fixed four-register file it adds byte strobes, registered responses with backpressure, change tracking and optional error signalling.

## Interface
- NUM_REGS, 2: number of RW data registers; range 1..min(DATA_W, (2^ADDR_W-4)/8)
- DATA_W, 32: data width; multiple of 8
- ADDR_W, 10: byte address width
- RST_EVEN, 0: reset value of DATA_i for even i
- RST_ODD, all ones: reset value of DATA_i for odd i
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte-lane write enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  access error; 0 when REGBANK_ERR_EN is not defined

## Operation
- Address map, i = 0..NUM_REGS-1:
  - DATA_i @ 8*i: RW
  - SR_DATA_i @ 8*i+4: RO mirror of DATA_i
  - STATUS @ 2^ADDR_W-4: bit i sticky, W1C; bits ≥ NUM_REGS read 0
  - All other addresses reserved: RAZ/WI
- Unaligned access (req_addr[1:0] != 0): RAZ/WI.
- Write to DATA_i: lanes with wstrb set take wdata; other lanes keep their value.
  - If the merged value differs from the old value, STATUS[i] sets.
  - wstrb = 0: no update, no status change.
- Write to STATUS: bits where the merged wdata is 1 clear.
- Write to SR_DATA_i: ignored.
- Reads return the register value sampled at the acceptance edge (pre-write state). They have no side effects.
- Response state: EMPTY (rsp_valid = 0) / FULL (rsp_valid = 1).
  - EMPTY -> FULL on acceptance.
  - FULL -> FULL on acceptance with rsp_ready.
  - FULL -> EMPTY on rsp_ready without acceptance.
- req_ready = !rsp_valid || rsp_ready (combinational). One request may be outstanding.

## Timing
- Reset: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, STATUS = 0, DATA_i = RST_EVEN/RST_ODD.
- Register writes and STATUS updates take effect at the acceptance edge.
- Response latency: rsp_valid rises 1 cycle after acceptance.
- Throughput: 1 access/cycle when rsp_ready is held high.
- While rsp_valid = 1 and rsp_ready = 0: rsp_rdata and rsp_err hold stable, and req_ready = 0.
- Back-to-back write then read of the same DATA_i: the read returns the new value.
- Reset asserted mid-transaction: the pending response is dropped and every register returns to its reset value. No response is issued after rst_n deasserts.

## Configuration
- REGBANK_ERR_EN defined: rsp_err = 1 for reserved addresses, unaligned addresses, and writes to SR_DATA_i.
  - RAZ/WI still applies to these accesses.
  - Errored writes never modify state.
- REGBANK_ERR_EN undefined: rsp_err is constant 0 and all such accesses are silently RAZ/WI.

## Test plan
- Reset, then read 0x000, 0x004, 0x008, 0x00C -> 0x00000000, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFF, each response 1 cycle after acceptance.
- Write 0x000 data 0xA5A5A5A5 wstrb 0b0011, then read 0x004 -> 0x0000A5A5; STATUS reads 0x1; write STATUS 0x1, then read STATUS -> 0x0.
- Write 0x008 data 0xFFFFFFFF -> STATUS[1] stays 0 (no change); write 0x004 -> ignored, and rsp_err = 1 only with REGBANK_ERR_EN defined.
- Read 0x010, 0x002 and 0x3F8 -> rdata 0; rsp_err = 1 with REGBANK_ERR_EN defined, 0 without.
- Hold rsp_ready = 0 for 3 cycles after a read of 0x008 -> req_ready = 0, rsp_rdata stable at 0xFFFFFFFF; release -> next request accepted the same cycle.
- Assert rst_n low while rsp_valid = 1 after a write to 0x000 -> rsp_valid = 0 and DATA0 = 0 immediately, with no response after release.
